// File: rtl/timer_compare.sv
// Compare stage of a 64-bit system timer: compare register, rising-edge match
// detection into a sticky W1C status bit, masked interrupt and high-word snapshot.
module timer_compare #(
    parameter logic [63:0] DEFAULT_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] cnt,
    input  logic [31:0] wdata,
    input  logic        cmp0_wr_sel,
    input  logic        cmp1_wr_sel,
    input  logic        cmp_en,
    input  logic        int_en,
    input  logic        int_st_wr_sel,
    input  logic        cnt_lo_rd_sel,
    output logic [63:0] cmp,
    output logic        int_st,
    output logic        tim_int,
    output logic [31:0] cnt_hi_snap
);

    logic match;
    logic match_d;
    logic set_evt;
    logic clr_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp <= DEFAULT_CMP;
        end else begin
            if (cmp0_wr_sel) cmp[31:0]  <= wdata;
            if (cmp1_wr_sel) cmp[63:32] <= wdata;
        end
    end

    // Full-width equality only; a match on one half alone must never fire.
    assign match   = cmp_en & (cnt == cmp);
    assign set_evt = match & ~match_d;
    assign clr_evt = int_st_wr_sel & wdata[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_d <= 1'b0;
            int_st  <= 1'b0;
        end else begin
            match_d <= match;
            // A new match outranks a software clear so no event is lost.
            if (set_evt)      int_st <= 1'b1;
            else if (clr_evt) int_st <= 1'b0;
        end
    end

    assign tim_int = int_st & int_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             cnt_hi_snap <= 32'h0;
        else if (cnt_lo_rd_sel) cnt_hi_snap <= cnt[63:32];
    end

endmodule

// File: tb/tb_timer_compare.sv
// Directed vector bench for timer_compare: per-cycle table plus hand-written
// sequences for combinational masking and asynchronous reset.
module tb_timer_compare;

    logic        clk;
    logic        rst_n;
    logic [63:0] cnt;
    logic [31:0] wdata;
    logic        cmp0_wr_sel;
    logic        cmp1_wr_sel;
    logic        cmp_en;
    logic        int_en;
    logic        int_st_wr_sel;
    logic        cnt_lo_rd_sel;
    logic [63:0] cmp;
    logic        int_st;
    logic        tim_int;
    logic [31:0] cnt_hi_snap;

    int total;
    int bad;

    timer_compare dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cnt           (cnt),
        .wdata         (wdata),
        .cmp0_wr_sel   (cmp0_wr_sel),
        .cmp1_wr_sel   (cmp1_wr_sel),
        .cmp_en        (cmp_en),
        .int_en        (int_en),
        .int_st_wr_sel (int_st_wr_sel),
        .cnt_lo_rd_sel (cnt_lo_rd_sel),
        .cmp           (cmp),
        .int_st        (int_st),
        .tim_int       (tim_int),
        .cnt_hi_snap   (cnt_hi_snap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] cnt;
        logic [31:0] wdata;
        logic        c0;
        logic        c1;
        logic        en;
        logic        ie;
        logic        sw;
        logic        rd;
        logic [63:0] e_cmp;
        logic        e_st;
        logic [31:0] e_snap;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [63:0] c, input logic [31:0] wd,
                       input logic c0, input logic c1, input logic en,
                       input logic ie, input logic sw, input logic rd,
                       input logic [63:0] e_cmp, input logic e_st,
                       input logic [31:0] e_snap);
        vec_t v;
        v.cnt = c; v.wdata = wd; v.c0 = c0; v.c1 = c1; v.en = en; v.ie = ie;
        v.sw = sw; v.rd = rd; v.e_cmp = e_cmp; v.e_st = e_st; v.e_snap = e_snap;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wdata = 32'h0; cmp0_wr_sel = 1'b0; cmp1_wr_sel = 1'b0;
        int_st_wr_sel = 1'b0; cnt_lo_rd_sel = 1'b0;
    endtask

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        cnt   = 64'h0;
        cmp_en = 1'b0;
        int_en = 1'b0;
        idle_inputs();

        //   cnt                      wdata        c0 c1 en ie sw rd  exp_cmp                  st snap
        add(64'h0,                   32'h10,       1, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_0000_0010, 0, 32'h0);
        add(64'h1,                   32'h0,        0, 1, 0, 0, 0, 0, 64'h10,                  0, 32'h0);
        add(64'hF,                   32'h0,        0, 0, 1, 1, 0, 0, 64'h10,                  0, 32'h0);
        add(64'h10,                  32'h0,        0, 0, 1, 1, 0, 0, 64'h10,                  1, 32'h0);
        add(64'h11,                  32'h0,        0, 0, 1, 1, 0, 0, 64'h10,                  1, 32'h0);
        add(64'h11,                  32'h0,        0, 0, 1, 1, 1, 0, 64'h10,                  1, 32'h0);
        add(64'h11,                  32'h1,        0, 0, 1, 1, 1, 0, 64'h10,                  0, 32'h0);
        add(64'h10,                  32'h0,        0, 0, 1, 1, 0, 0, 64'h10,                  1, 32'h0);
        add(64'h10,                  32'h1,        0, 0, 1, 1, 1, 0, 64'h10,                  0, 32'h0);
        add(64'h10,                  32'h0,        0, 0, 1, 1, 0, 0, 64'h10,                  0, 32'h0);
        add(64'h10,                  32'h0,        0, 0, 1, 1, 0, 0, 64'h10,                  0, 32'h0);
        add(64'h11,                  32'h0,        0, 0, 1, 1, 0, 0, 64'h10,                  0, 32'h0);
        add(64'h10,                  32'h1,        0, 0, 1, 1, 1, 0, 64'h10,                  1, 32'h0);
        add(64'h11,                  32'h1,        0, 0, 1, 0, 1, 0, 64'h10,                  0, 32'h0);
        add(64'h10,                  32'h0,        0, 0, 1, 0, 0, 0, 64'h10,                  1, 32'h0);
        add(64'h11,                  32'h0,        0, 0, 1, 1, 0, 0, 64'h10,                  1, 32'h0);
        add(64'h11,                  32'h1,        0, 0, 1, 1, 1, 0, 64'h10,                  0, 32'h0);
        add(64'h10,                  32'h0,        0, 0, 0, 1, 0, 0, 64'h10,                  0, 32'h0);
        add(64'h10,                  32'h0,        0, 0, 1, 1, 0, 0, 64'h10,                  1, 32'h0);
        add(64'h11,                  32'h1,        0, 0, 1, 1, 1, 0, 64'h10,                  0, 32'h0);
        add(64'h20,                  32'h20,       1, 0, 1, 1, 0, 0, 64'h20,                  0, 32'h0);
        add(64'h20,                  32'h0,        0, 0, 1, 1, 0, 0, 64'h20,                  1, 32'h0);
        add(64'h30,                  32'h31,       1, 0, 1, 1, 1, 0, 64'h31,                  0, 32'h0);
        add(64'h31,                  32'h40,       1, 0, 1, 1, 0, 0, 64'h40,                  1, 32'h0);
        add(64'h31,                  32'h1,        0, 0, 1, 1, 1, 0, 64'h40,                  0, 32'h0);
        add(64'h0000_0001_0000_0040, 32'h0,        0, 0, 1, 1, 0, 0, 64'h40,                  0, 32'h0);
        add(64'h40,                  32'h0,        0, 0, 1, 1, 0, 0, 64'h40,                  1, 32'h0);
        add(64'h41,                  32'h1,        0, 0, 1, 1, 1, 0, 64'h40,                  0, 32'h0);
        add(64'h0,                   32'hABCD,     1, 1, 1, 1, 0, 0, 64'h0000_ABCD_0000_ABCD, 0, 32'h0);
        add(64'h0000_0001_FFFF_FFFF, 32'h0,        0, 0, 1, 1, 0, 1, 64'h0000_ABCD_0000_ABCD, 0, 32'h1);
        add(64'h0000_0002_0000_0000, 32'h0,        0, 0, 1, 1, 0, 0, 64'h0000_ABCD_0000_ABCD, 0, 32'h1);
        add(64'h0000_0002_0000_0000, 32'h0,        0, 0, 1, 1, 0, 1, 64'h0000_ABCD_0000_ABCD, 0, 32'h2);
        add(64'hFFFF_FFFF_FFFF_FFFE, 32'hFFFF_FFFF, 1, 1, 1, 1, 0, 0, ONES,                    0, 32'h2);
        add(ONES,                    32'h0,        0, 0, 1, 1, 0, 0, ONES,                    1, 32'h2);
        add(64'h0,                   32'h1,        0, 0, 1, 1, 1, 0, ONES,                    0, 32'h2);
        add(64'h1,                   32'h0,        0, 0, 1, 1, 0, 0, ONES,                    0, 32'h2);

        // reset state
        #12;
        chk("rst_cmp", cmp, ONES);
        chk("rst_int_st", {63'h0, int_st}, 64'h0);
        chk("rst_tim_int", {63'h0, tim_int}, 64'h0);
        chk("rst_snap", {32'h0, cnt_hi_snap}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            cnt = vecs[i].cnt; wdata = vecs[i].wdata;
            cmp0_wr_sel = vecs[i].c0; cmp1_wr_sel = vecs[i].c1;
            cmp_en = vecs[i].en; int_en = vecs[i].ie;
            int_st_wr_sel = vecs[i].sw; cnt_lo_rd_sel = vecs[i].rd;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_cmp", i), cmp, vecs[i].e_cmp);
            chk($sformatf("v%0d_int_st", i), {63'h0, int_st}, {63'h0, vecs[i].e_st});
            chk($sformatf("v%0d_tim_int", i), {63'h0, tim_int}, {63'h0, vecs[i].e_st & vecs[i].ie});
            chk($sformatf("v%0d_snap", i), {32'h0, cnt_hi_snap}, {32'h0, vecs[i].e_snap});
        end

        // int_en masks the output combinationally without touching status
        @(negedge clk);
        idle_inputs();
        cnt = ONES; cmp_en = 1'b1; int_en = 1'b0;
        @(posedge clk);
        #1;
        chk("mask_st", {63'h0, int_st}, 64'h1);
        chk("mask_tim_off", {63'h0, tim_int}, 64'h0);
        #1 int_en = 1'b1;
        #1;
        chk("mask_tim_on", {63'h0, tim_int}, 64'h1);
        int_en = 1'b0;
        #1;
        chk("mask_tim_off2", {63'h0, tim_int}, 64'h0);
        chk("mask_st2", {63'h0, int_st}, 64'h1);

        // asynchronous reset mid-operation
        @(negedge clk);
        int_en = 1'b1; wdata = 32'h10; cmp0_wr_sel = 1'b1;
        @(negedge clk);
        wdata = 32'h0; cmp0_wr_sel = 1'b0; cmp1_wr_sel = 1'b1; cnt = 64'h5;
        @(negedge clk);
        idle_inputs();
        cnt = 64'h6;
        chk("pre_rst_cmp", cmp, 64'h10);
        chk("pre_rst_st", {63'h0, int_st}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cmp", cmp, ONES);
        chk("arst_int_st", {63'h0, int_st}, 64'h0);
        chk("arst_tim_int", {63'h0, tim_int}, 64'h0);
        chk("arst_snap", {32'h0, cnt_hi_snap}, 64'h0);

        // first edge after release sees a match against the default compare
        @(negedge clk);
        cnt = ONES; cmp_en = 1'b1;
        @(negedge clk);
        chk("held_rst_st", {63'h0, int_st}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_st", {63'h0, int_st}, 64'h1);
        chk("release_tim", {63'h0, tim_int}, 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
